// File: rtl/ir_fetch.sv
// rtl/ir_fetch.sv - three-word instruction fetcher: device/address/data words read at pc, pc+1, pc+2
module ir_fetch #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            i_ir_reg_en,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_irp,
  input  logic                  i_stop,
  output logic                  o_mem_req,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [DATA_WIDTH-1:0] o_device,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_F_DEV  = 3'd1;
  localparam logic [2:0] S_F_ADDR = 3'd2;
  localparam logic [2:0] S_F_DATA = 3'd3;
  localparam logic [2:0] S_ISSUE  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] MODE_RST  = 2'b01;
  localparam logic [1:0] MODE_WORK = 2'b10;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(1);

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] device_q;
  logic [DATA_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Priority chain: controller reset, then halt, then jump, then normal sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      device_q  <= '0;
      address_q <= '0;
      data_q    <= '0;
    end else if (i_ir_reg_en == MODE_RST) begin
      state     <= S_IDLE;
      pc        <= '0;
      device_q  <= '0;
      address_q <= '0;
      data_q    <= '0;
    end else if (i_stop && state != S_IDLE) begin
      state <= S_HALT;
    end else if (state == S_HALT) begin
      state <= S_HALT;
    end else if (i_jump && state != S_IDLE) begin
      pc    <= i_irp;
      state <= S_F_DEV;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_ir_reg_en == MODE_WORK) state <= S_F_DEV;
        end
        S_F_DEV: begin
          if (i_mem_ack) begin
            device_q <= i_mem_data;
            pc       <= pc + PC_STEP;
            state    <= S_F_ADDR;
          end
        end
        S_F_ADDR: begin
          if (i_mem_ack) begin
            address_q <= i_mem_data;
            pc        <= pc + PC_STEP;
            state     <= S_F_DATA;
          end
        end
        S_F_DATA: begin
          if (i_mem_ack) begin
            data_q <= i_mem_data;
            pc     <= pc + PC_STEP;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Mode is sampled only here, so a fetch in flight always completes.
          if (i_ready) state <= (i_ir_reg_en == MODE_WORK) ? S_F_DEV : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_req  = (state == S_F_DEV) || (state == S_F_ADDR) || (state == S_F_DATA);
  assign o_mem_addr = pc;
  assign o_valid    = (state == S_ISSUE);
  assign o_halted   = (state == S_HALT);
  assign o_pc       = pc;
  assign o_device   = device_q;
  assign o_address  = address_q;
  assign o_data     = data_q;

endmodule

// File: tb/tb_ir_fetch.sv
// tb/tb_ir_fetch.sv - scoreboard bench for ir_fetch with a latency-configurable memory model
module tb_ir_fetch;

  logic        clk;
  logic        rst_n;
  logic [1:0]  i_ir_reg_en;
  logic        i_jump;
  logic [15:0] i_irp;
  logic        i_stop;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack;
  logic [15:0] i_mem_data;
  logic [15:0] o_device;
  logic [15:0] o_address;
  logic [15:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_pc;
  logic        o_halted;

  ir_fetch #(.DATA_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ir_reg_en (i_ir_reg_en),
    .i_jump      (i_jump),
    .i_irp       (i_irp),
    .i_stop      (i_stop),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
    .i_mem_data  (i_mem_data),
    .o_device    (o_device),
    .o_address   (o_address),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_pc        (o_pc),
    .o_halted    (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dev;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  int   ack_delay = 0;
  int   wait_cnt = 0;
  bit   rand_delay = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h0003;
      16'h0001: mem_word = 16'h0005;
      16'h0002: mem_word = 16'h00AA;
      default:  mem_word = a * 16'd3 + 16'd7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] p);
    exp_t e;
    e.dev  = mem_word(p);
    e.addr = mem_word(p + 16'd1);
    e.data = mem_word(p + 16'd2);
    e.pc   = p + 16'd3;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!o_valid && n < max) begin
      tick();
      n++;
    end
    chk("valid_seen", {31'd0, o_valid}, 32'd1);
  endtask

  // Memory: acks after ack_delay idle cycles of a request, data valid with the ack.
  always @(negedge clk) begin
    if (rst_n && o_mem_req) begin
      if (wait_cnt >= ack_delay) begin
        i_mem_ack  = 1'b1;
        i_mem_data = mem_word(o_mem_addr);
        wait_cnt   = 0;
        if (rand_delay) ack_delay = $urandom_range(0, 2);
      end else begin
        i_mem_ack  = 1'b0;
        i_mem_data = 16'hDEAD;
        wait_cnt++;
      end
    end else begin
      i_mem_ack  = 1'b0;
      i_mem_data = 16'hDEAD;
      wait_cnt   = 0;
    end
  end

  // Consumer side: each accepted instruction is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_device",  {16'd0, o_device},  {16'd0, e.dev});
        chk("sb_address", {16'd0, o_address}, {16'd0, e.addr});
        chk("sb_data",    {16'd0, o_data},    {16'd0, e.data});
        chk("sb_pc",      {16'd0, o_pc},      {16'd0, e.pc});
        pops++;
      end
    end
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    i_ir_reg_en = 2'b00;
    i_jump      = 1'b0;
    i_irp       = 16'h0000;
    i_stop      = 1'b0;
    i_ready     = 1'b1;
    i_mem_ack   = 1'b0;
    i_mem_data  = 16'h0000;
    #12;
    chk("rst_req",    {31'd0, o_mem_req}, 32'd0);
    chk("rst_valid",  {31'd0, o_valid},   32'd0);
    chk("rst_halted", {31'd0, o_halted},  32'd0);
    chk("rst_pc",     {16'd0, o_pc},       32'd0);
    chk("rst_addr",   {16'd0, o_mem_addr}, 32'd0);
    chk("rst_fields", {o_device, o_address | o_data}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_hold", {31'd0, o_mem_req}, 32'd0);

    // Basic instruction with ack tied high: four-cycle latency.
    ack_delay = 0;
    push_exp(16'h0000);
    i_ir_reg_en = 2'b10;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_valid && n < 50);
    chk("latency4", n, 32'd4);
    chk("basic_pc", {16'd0, o_pc}, 32'd3);
    i_ir_reg_en = 2'b00;
    tick();
    chk("basic_drop_valid", {31'd0, o_valid}, 32'd0);
    chk("basic_idle",       {31'd0, o_mem_req}, 32'd0);

    // Controller reset clears pc and fields.
    i_ir_reg_en = 2'b01;
    tick();
    chk("mrst_pc",     {16'd0, o_pc}, 32'd0);
    chk("mrst_fields", {o_device, o_address | o_data}, 32'd0);

    // Three wait cycles per word: address held across waits.
    ack_delay = 3;
    push_exp(16'h0000);
    i_ir_reg_en = 2'b10;
    n = 0;
    while (!o_mem_req && n < 10) begin
      tick();
      n++;
    end
    n = 0;
    while (!o_valid && n < 100) begin
      if (o_mem_req) chk("slow_addr_hold", {16'd0, o_mem_addr}, n / 4);
      tick();
      n++;
    end
    chk("slow_latency", n, 32'd12);
    i_ir_reg_en = 2'b00;
    tick();
    ack_delay = 0;

    // Jump to 0xFFFF out of F_DEV with ack pending, then wrap-around fetch.
    push_exp(16'hFFFF);
    i_ir_reg_en = 2'b10;
    tick();
    i_jump = 1'b1;
    i_irp  = 16'hFFFF;
    tick();
    i_jump = 1'b0;
    i_ir_reg_en = 2'b00;
    chk("wrap_start_addr", {16'd0, o_mem_addr}, 32'h0000FFFF);
    wait_valid(50, n);
    chk("wrap_pc", {16'd0, o_pc}, 32'd2);
    tick();

    // Jump during F_ADDR with ack high: ack discarded, refetch from 0x40.
    push_exp(16'h0040);
    i_ir_reg_en = 2'b10;
    tick();
    tick();
    chk("pre_jump_pc", {16'd0, o_pc}, 32'd3);
    i_jump = 1'b1;
    i_irp  = 16'h0040;
    tick();
    i_jump = 1'b0;
    i_ir_reg_en = 2'b00;
    chk("jump_addr", {16'd0, o_mem_addr}, 32'h40);
    chk("jump_req",  {31'd0, o_mem_req},  32'd1);
    wait_valid(50, n);
    tick();
    chk("leave_work_idle", {31'd0, o_mem_req | o_valid}, 32'd0);

    // Stall in ISSUE, then halt; jump ignored; controller reset exits.
    i_ready = 1'b0;
    i_ir_reg_en = 2'b10;
    tick();
    i_ir_reg_en = 2'b00;
    wait_valid(50, n);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'd0, o_valid}, 32'd1);
      chk("stall_dev",   {16'd0, o_device},  {16'd0, mem_word(16'h0043)});
      chk("stall_data",  {16'd0, o_data},    {16'd0, mem_word(16'h0045)});
      tick();
    end
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("halt_flag",  {31'd0, o_halted}, 32'd1);
    chk("halt_valid", {31'd0, o_valid | o_mem_req}, 32'd0);
    chk("halt_pc",    {16'd0, o_pc}, 32'h46);
    i_jump = 1'b1;
    i_irp  = 16'h0010;
    tick();
    i_jump = 1'b0;
    chk("halt_jump_ign", {16'd0, o_pc}, 32'h46);
    chk("halt_stays",    {31'd0, o_halted}, 32'd1);
    i_ir_reg_en = 2'b01;
    tick();
    i_ir_reg_en = 2'b00;
    chk("unhalt_flag", {31'd0, o_halted}, 32'd0);
    chk("unhalt_pc",   {16'd0, o_pc}, 32'd0);
    tick();
    chk("unhalt_idle", {31'd0, o_mem_req}, 32'd0);
    i_ready = 1'b1;

    // Async reset while in F_DATA.
    i_ir_reg_en = 2'b10;
    tick();
    tick();
    tick();
    chk("fdata_addr", {16'd0, o_mem_addr}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",   {31'd0, o_mem_req}, 32'd0);
    chk("arst_valid", {31'd0, o_valid},   32'd0);
    chk("arst_pc",    {16'd0, o_pc},       32'd0);
    i_ir_reg_en = 2'b00;
    tick();
    #3;
    rst_n = 1'b1;
    repeat (2) tick();
    chk("arst_idle", {31'd0, o_mem_req}, 32'd0);

    // Back-to-back stream with random memory latency.
    rand_delay = 1'b1;
    pops = 0;
    push_exp(16'd0);
    push_exp(16'd3);
    push_exp(16'd6);
    push_exp(16'd9);
    i_ir_reg_en = 2'b10;
    n = 0;
    while (pops < 3 && n < 2000) begin
      tick();
      n++;
    end
    i_ir_reg_en = 2'b00;
    while (pops < 4 && n < 2000) begin
      tick();
      n++;
    end
    chk("stream_pops", pops, 32'd4);
    repeat (2) tick();
    chk("stream_idle", {31'd0, o_mem_req | o_valid}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_fetch.md
IR_FETCH -- requirements
Module: ir_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of program memory words, instruction fields and program counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port i_ir_reg_en, input, 2, mode from controller: 00 IDLE, 01 RST, 10 WORK, 11 treated as IDLE.
REQ-005 SHALL have port i_jump, input, 1, single-cycle request to load the program counter from i_irp.
REQ-006 SHALL have port i_irp, input, DATA_WIDTH, jump target address.
REQ-007 SHALL have port i_stop, input, 1, halt request.
REQ-008 SHALL have port o_mem_req, output, 1, program memory read request.
REQ-009 SHALL have port o_mem_addr, output, DATA_WIDTH, read address (current pc).
REQ-010 SHALL have port i_mem_ack, input, 1, read completion; i_mem_data valid in the same cycle.
REQ-011 SHALL have port i_mem_data, input, DATA_WIDTH, read data.
REQ-012 SHALL have port o_device / o_address / o_data, output, DATA_WIDTH each, decoded instruction fields.
REQ-013 SHALL have port o_valid, output, 1, instruction fields valid.
REQ-014 SHALL have port i_ready, input, 1, consumer accepts the instruction.
REQ-015 SHALL have port o_pc, output, DATA_WIDTH, current program counter.
REQ-016 SHALL have port o_halted, output, 1, high while in HALT.

Function
REQ-017 SHALL implement states IDLE, F_DEV, F_ADDR, F_DATA, ISSUE, HALT.
REQ-018 Each instruction SHALL be three consecutive words: device, address, data, fetched at pc, pc+1, pc+2.
REQ-019 IDLE: o_mem_req=0; i_ir_reg_en==10 -> F_DEV next cycle.
REQ-020 F_DEV/F_ADDR/F_DATA SHALL hold o_mem_req=1, o_mem_addr=pc stable until i_mem_ack.
REQ-021 On i_mem_ack in a fetch state SHALL capture i_mem_data into the matching field register, increment pc by 1 modulo 2^DATA_WIDTH (all-ones wraps to 0), advance F_DEV->F_ADDR->F_DATA->ISSUE.
REQ-022 ISSUE: o_valid=1, o_mem_req=0, fields held stable until i_ready=1.
REQ-023 ISSUE with i_ready=1: i_ir_reg_en==10 -> F_DEV, else -> IDLE; o_valid falls next cycle.
REQ-024 i_ir_reg_en leaving 10 during a fetch state SHALL NOT abort it; the instruction completes through ISSUE, then IDLE.
REQ-025 i_ir_reg_en==01 in any state SHALL synchronously clear pc, field registers, o_valid and go to IDLE.
REQ-026 i_jump=1 in any state except HALT/IDLE SHALL load pc<=i_irp, discard any partial or pending instruction (o_valid 0 next cycle), go to F_DEV.
REQ-027 i_jump coincident with i_mem_ack SHALL discard the ack data; pc takes i_irp, not pc+1.
REQ-028 i_jump coincident with ISSUE and i_ready=1: instruction counts as consumed; pc<=i_irp; -> F_DEV.
REQ-029 i_stop=1 in any state except IDLE SHALL go to HALT, drop o_mem_req and o_valid, keep pc.
REQ-030 HALT: o_halted=1, ignores i_jump and i_mem_ack; exits only via i_ir_reg_en==01 or rst_n.
REQ-031 Priority SHALL be rst_n > i_ir_reg_en==01 > i_stop > i_jump > normal flow.
REQ-032 o_pc SHALL equal the pc register; o_mem_addr SHALL equal pc whenever o_mem_req=1.
REQ-033 Minimum latency with i_mem_ack tied high: WORK seen in IDLE -> o_valid high 4 cycles later.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, pc=0, fields=0, o_valid=0, o_mem_req=0, o_halted=0, o_mem_addr=0.
REQ-035 After rst_n rises, block SHALL stay IDLE until i_ir_reg_en==10.

Verification
REQ-036 Memory 0:3,1:5,2:0xAA, ack always high, mode 10, ready high -> o_valid 4 cycles after WORK, device=3 address=5 data=0xAA, o_pc=3.
REQ-037 Ack delayed 3 cycles per word -> o_mem_addr stable 0,1,2 across waits; fields correct; o_valid after 12 cycles.
REQ-038 i_jump with i_irp=0x40 during F_ADDR while ack high -> ack discarded, next o_mem_addr=0x40 in F_DEV.
REQ-039 pc=0xFFFF at F_DEV -> fields from 0xFFFF,0x0000,0x0001; o_pc=0x0002.
REQ-040 i_ready low 5 cycles in ISSUE, then i_stop -> fields stable, then HALT, o_halted=1, i_jump ignored; mode 01 -> IDLE, pc=0.
REQ-041 rst_n asserted mid F_DATA -> o_mem_req and o_valid 0 immediately, pc=0, IDLE after release.
